// File: rtl/package_sorter_param.sv
// Weight-band package sorter: settles a nonzero scale reading, classifies it against a threshold
// table and keeps saturating per-band counters. Optional feature macro: PKG_OVF_STICKY_EN (grp_ovf flags).
module package_sorter_param #(
    parameter int W_WIDTH    = 12,
    parameter int NUM_GRP    = 6,
    parameter int CNT_WIDTH  = 8,
    parameter int SETTLE_CYC = 2,
    parameter logic [(NUM_GRP-1)*W_WIDTH-1:0] THRESH = {W_WIDTH'(2000), W_WIDTH'(1500),
                                                         W_WIDTH'(750),  W_WIDTH'(500),
                                                         W_WIDTH'(250)},
    localparam int GRP_IDX_W = $clog2(NUM_GRP+1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [W_WIDTH-1:0]           weight,
    input  logic                         cnt_clr,
    output logic [NUM_GRP*CNT_WIDTH-1:0] grp_cnt,
    output logic [GRP_IDX_W-1:0]         current_grp,
    output logic                         pkg_valid,
`ifdef PKG_OVF_STICKY_EN
    output logic [NUM_GRP-1:0]           grp_ovf,
`endif
    output logic [1:0]                   fsm_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam int ST_W = $clog2(SETTLE_CYC+1);

    logic [1:0]           state;
    logic [W_WIDTH-1:0]   w_hold;
    logic [ST_W-1:0]      st;
    logic [ST_W-1:0]      st_inc;
    logic                 do_count;
    logic [W_WIDTH-1:0]   count_w;
    logic [GRP_IDX_W-1:0] band;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_GRP];

    // Thresholds are ascending, so the last slice exceeded decides the band.
    function automatic logic [GRP_IDX_W-1:0] classify(input logic [W_WIDTH-1:0] w);
        logic [GRP_IDX_W-1:0] b;
        b = GRP_IDX_W'(1);
        for (int i = 0; i < NUM_GRP-1; i++) begin
            if (w > THRESH[i*W_WIDTH +: W_WIDTH]) b = GRP_IDX_W'(i+2);
        end
        return b;
    endfunction

    assign st_inc    = st + ST_W'(1);
    assign fsm_state = state;

    always_comb begin
        do_count = 1'b0;
        case (state)
            S_IDLE:   do_count = (weight != '0) && (SETTLE_CYC == 1);
            S_SETTLE: do_count = (weight != '0) && (weight == w_hold) && (st_inc == ST_W'(SETTLE_CYC));
            default:  do_count = 1'b0;
        endcase
    end

    // With SETTLE_CYC==1 the count happens in IDLE before w_hold is loaded.
    assign count_w = (state == S_IDLE) ? weight : w_hold;
    assign band    = classify(count_w);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            w_hold      <= '0;
            st          <= '0;
            current_grp <= '0;
            pkg_valid   <= 1'b0;
        end else begin
            pkg_valid <= do_count;
            case (state)
                S_IDLE: begin
                    if (weight != '0) begin
                        w_hold <= weight;
                        st     <= ST_W'(1);
                        state  <= do_count ? S_LOCKED : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (weight == '0) begin
                        state <= S_IDLE;
                    end else if (weight != w_hold) begin
                        w_hold <= weight;
                        st     <= ST_W'(1);
                    end else begin
                        st <= st_inc;
                        if (do_count) state <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (weight == '0) begin
                        state       <= S_IDLE;
                        current_grp <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (do_count) current_grp <= band;
        end
    end

    // Clear beats a coincident count; counters stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_GRP; k++) cnt_q[k] <= '0;
        end else if (cnt_clr) begin
            for (int k = 0; k < NUM_GRP; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_GRP; k++) begin
                if (do_count && band == GRP_IDX_W'(k+1) && cnt_q[k] != '1)
                    cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

`ifdef PKG_OVF_STICKY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grp_ovf <= '0;
        end else if (cnt_clr) begin
            grp_ovf <= '0;
        end else begin
            for (int k = 0; k < NUM_GRP; k++) begin
                if (do_count && band == GRP_IDX_W'(k+1) && cnt_q[k] == '1) grp_ovf[k] <= 1'b1;
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_cnt
        assign grp_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

endmodule
